// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Round-robin arbiter that shares one multi-cycle FloatAdder among NREQ
//   requesters. A granted request is latched onto the adder operands, issued
//   with a one-cycle InputValid pulse, and the adder result is held for the
//   granted requester until it is consumed. One operation in flight at a time.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  WAIT cycles before an abort (only with FPARB_TIMEOUT_EN)
//
// Optional feature macro: FPARB_TIMEOUT_EN
//   Defined: a WAIT-cycle counter aborts a stuck operation with a qNaN result
//   and RespError=1. Undefined: WAIT lasts until the adder answers.
//
// Ports
//   Clock, Reset              clock; synchronous active-high reset
//   ReqValid/ReqReady         per-requester request handshake (ReqReady one-hot)
//   ReqOp1/ReqOp2             packed operands, requester i at [32i+31:32i]
//   RespValid/RespReady       per-requester response handshake (RespValid one-hot)
//   RespResult/RespError      result for the RespValid holder, abort flag
//   AdderOp1/AdderOp2         operands to the FloatAdder
//   AdderInValid              one-cycle issue pulse to the FloatAdder
//   AdderResult/AdderResValid result from the FloatAdder
//   Busy                      high whenever the arbiter is not idle
module fp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NREQ-1:0]     ReqValid,
  output logic [NREQ-1:0]     ReqReady,
  input  logic [NREQ*32-1:0]  ReqOp1,
  input  logic [NREQ*32-1:0]  ReqOp2,
  output logic [NREQ-1:0]     RespValid,
  input  logic [NREQ-1:0]     RespReady,
  output logic [31:0]         RespResult,
  output logic                RespError,
  output logic [31:0]         AdderOp1,
  output logic [31:0]         AdderOp2,
  output logic                AdderInValid,
  input  logic [31:0]         AdderResult,
  input  logic                AdderResValid,
  output logic                Busy
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [GW-1:0]   rr_r, grant_r, pick_s, idx_s;
  logic            pick_found_s, accept_s;
  logic            wait_first_r;
  logic            take_result_s, take_timeout_s, timeout_s;
  logic [NREQ-1:0] one_hot_base_s;
  logic [31:0]     op1_arr_s [NREQ];
  logic [31:0]     op2_arr_s [NREQ];

  assign one_hot_base_s = {{(NREQ-1){1'b0}}, 1'b1};

  // Unpack the per-requester operand slices
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op1_arr_s[i] = ReqOp1[32*i +: 32];
    assign op2_arr_s[i] = ReqOp2[32*i +: 32];
  end

  // Round-robin search: first valid requester at or above rr_r, wrapping
  always_comb begin
    pick_s       = {GW{1'b0}};
    idx_s        = {GW{1'b0}};
    pick_found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s        = GW'((int'(rr_r) + k) % NREQ);
      pick_s       = (!pick_found_s && ReqValid[idx_s]) ? idx_s : pick_s;
      pick_found_s = pick_found_s | ReqValid[idx_s];
    end
  end

`ifdef FPARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_r;

  // WAIT-cycle counter; zero outside WAIT so it starts clean on every entry
  always_ff @(posedge Clock) begin
    if (Reset || (state_r != S_WAIT)) begin
      wait_cnt_r <= {CW{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end
  end

  // Fires in the TIMEOUT-th WAIT cycle
  assign timeout_s = (state_r == S_WAIT) && (wait_cnt_r == CW'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
  // TIMEOUT only sizes the abort counter, which this build does not have
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Next-state logic and the combinational accept strobe
  always_comb begin
    state_nxt_s    = state_r;
    ReqReady       = {NREQ{1'b0}};
    accept_s       = 1'b0;
    take_result_s  = 1'b0;
    take_timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pick_found_s && !Reset) begin
          accept_s    = 1'b1;
          ReqReady    = one_hot_base_s << pick_s;
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        // First WAIT cycle may still see ResultValid left over from the last op;
        // a real result beats a simultaneous timeout.
        if (!wait_first_r && AdderResValid) begin
          take_result_s = 1'b1;
          state_nxt_s   = S_RESP;
        end else if (timeout_s) begin
          take_timeout_s = 1'b1;
          state_nxt_s    = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (RespReady[grant_r]) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= S_IDLE;
      rr_r         <= {GW{1'b0}};
      grant_r      <= {GW{1'b0}};
      wait_first_r <= 1'b0;
      AdderOp1     <= 32'h0000_0000;
      AdderOp2     <= 32'h0000_0000;
      AdderInValid <= 1'b0;
      Busy         <= 1'b0;
      RespValid    <= {NREQ{1'b0}};
      RespResult   <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      wait_first_r <= (state_r == S_ISSUE);
      AdderInValid <= (state_nxt_s == S_ISSUE);
      Busy         <= (state_nxt_s != S_IDLE);
      RespValid    <= (state_nxt_s == S_RESP) ? (one_hot_base_s << grant_r) : {NREQ{1'b0}};
      if (accept_s) begin
        grant_r  <= pick_s;
        rr_r     <= (pick_s == GW'(NREQ - 1)) ? {GW{1'b0}} : (pick_s + GW'(1));
        AdderOp1 <= op1_arr_s[pick_s];
        AdderOp2 <= op2_arr_s[pick_s];
      end
      if (take_result_s) begin
        RespResult <= AdderResult;
      end else if (take_timeout_s) begin
        RespResult <= 32'h7FC0_0000;
      end
    end
  end

`ifdef FPARB_TIMEOUT_EN
  // Abort flag travels with the captured result
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RespError <= 1'b0;
    end else if (take_result_s) begin
      RespError <= 1'b0;
    end else if (take_timeout_s) begin
      RespError <= 1'b1;
    end
  end
`else
  assign RespError = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: directed and randomized transactions against
// a FloatAdder stub and a round-robin reference model.
module tb_fp_add_arbiter;
  localparam int NREQ = 4;
  localparam int TOUT = 8;

  logic                Clock = 1'b0;
  logic                Reset;
  logic [NREQ-1:0]     ReqValid, ReqReady, RespValid, RespReady;
  logic [NREQ*32-1:0]  ReqOp1, ReqOp2;
  logic [31:0]         RespResult, AdderOp1, AdderOp2, AdderResult;
  logic                RespError, AdderInValid, AdderResValid, Busy;

  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  bit use_fixed = 1'b0;
  logic [31:0] op1_m [NREQ];
  logic [31:0] op2_m [NREQ];

  // adder stub controls / state
  int          stub_lat = 1;
  bit          stub_sticky = 1'b0;
  bit          stub_never = 1'b0;
  int          stub_cnt = 0;
  logic [31:0] stub_pend = 32'h0;
  logic [31:0] stub_res = 32'h0;
  logic        stub_valid = 1'b0;
  int          pulses = 0;

  fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp1(ReqOp1), .ReqOp2(ReqOp2),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespResult(RespResult), .RespError(RespError),
    .AdderOp1(AdderOp1), .AdderOp2(AdderOp2), .AdderInValid(AdderInValid),
    .AdderResult(AdderResult), .AdderResValid(AdderResValid),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Stand-in adder arithmetic: exact for the 1.0+2.0 case, otherwise an
  // order-sensitive tag so misrouted or swapped operands show up.
  function automatic logic [31:0] fake_add(logic [31:0] a, logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a + {b[30:0], b[31]}) ^ 32'h5A5A_0000;
  endfunction

  // Round-robin reference: first set bit of m at or after rr, wrapping
  function automatic int exp_grant(logic [NREQ-1:0] m, int rr);
    for (int k = 0; k < NREQ; k++)
      if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  // FloatAdder stub: result stub_lat edges after the issue edge; in sticky
  // mode the previous ResultValid stays high into the first WAIT cycle.
  always @(posedge Clock) begin
    if (AdderInValid) begin
      pulses    <= pulses + 1;
      stub_pend <= fake_add(AdderOp1, AdderOp2);
      stub_cnt  <= stub_never ? 0 : stub_lat;
      if (!stub_sticky) stub_valid <= 1'b0;
    end else if (stub_cnt != 0) begin
      if (stub_cnt == 1) begin
        stub_valid <= 1'b1;
        stub_res   <= stub_pend;
      end else begin
        stub_valid <= 1'b0;
      end
      stub_cnt <= stub_cnt - 1;
    end else if (!stub_sticky) begin
      stub_valid <= 1'b0;
    end
  end

  assign AdderResult   = stub_res;
  assign AdderResValid = stub_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(ReqReady), 32'd0);
    chk({tag, "_resp_valid"}, 32'(RespValid), 32'd0);
    chk({tag, "_resp_result"}, RespResult, 32'd0);
    chk({tag, "_resp_error"}, 32'(RespError), 32'd0);
    chk({tag, "_adder_op1"}, AdderOp1, 32'd0);
    chk({tag, "_adder_op2"}, AdderOp2, 32'd0);
    chk({tag, "_adder_inval"}, 32'(AdderInValid), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ReqValid = '1;
    RespReady = '0;
    repeat (2) @(negedge Clock);
    reset_values("rst");
    Reset = 1'b0;
    ReqValid = '0;
    rr_model = 0;
  endtask

  // One full transaction starting from an idle arbiter at a negedge
  task automatic run_txn(input logic [NREQ-1:0] mask, input int lat, input int hold,
                         input bit sticky, input bit keep);
    int g, cyc, p0;
    bit stable;
    logic [NREQ-1:0] oh, extra;
    logic [31:0] exp_res;
    stub_lat = lat;
    stub_sticky = sticky;
    for (int i = 0; i < NREQ; i++) begin
      op1_m[i] = $urandom;
      op2_m[i] = $urandom;
    end
    if (use_fixed) begin
      op1_m[0] = 32'h3F80_0000;
      op2_m[0] = 32'h4000_0000;
    end
    for (int i = 0; i < NREQ; i++) begin
      ReqOp1[32*i +: 32] = op1_m[i];
      ReqOp2[32*i +: 32] = op2_m[i];
    end
    ReqValid = mask;
    RespReady = '0;
    g = exp_grant(mask, rr_model);
    oh = NREQ'(1) << g;
    exp_res = fake_add(op1_m[g], op2_m[g]);
    p0 = pulses;
    #1;
    chk("req_ready", 32'(ReqReady), 32'(oh));
    @(negedge Clock);
    chk("issue_pulse", 32'(AdderInValid), 32'd1);
    chk("issue_op1", AdderOp1, op1_m[g]);
    chk("issue_op2", AdderOp2, op2_m[g]);
    chk("issue_busy", 32'(Busy), 32'd1);
    extra = '0;
    cyc = 1;
    while (RespValid === '0 && cyc < 200) begin
      extra |= ReqReady;
      @(negedge Clock);
      cyc++;
    end
    chk("no_extra_grant", 32'(extra), 32'd0);
    chk("resp_valid", 32'(RespValid), 32'(oh));
    chk("resp_result", RespResult, exp_res);
    chk("resp_error", 32'(RespError), 32'd0);
    chk("latency", cyc, lat + 3);
    chk("one_pulse", pulses - p0, 32'd1);
    RespReady = ~oh;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge Clock);
      if (RespValid !== oh || RespResult !== exp_res || Busy !== 1'b1 || ReqReady !== '0)
        stable = 1'b0;
    end
    if (hold > 0) chk("resp_hold", 32'(stable), 32'd1);
    RespReady = oh;
    if (!keep) ReqValid = '0;
    @(negedge Clock);
    chk("resp_drop", 32'(RespValid), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("op_held", AdderOp1, op1_m[g]);
    RespReady = '0;
    rr_model = (g + 1) % NREQ;
  endtask

  initial begin
    logic [NREQ-1:0] seen;
    int cyc;
    Reset = 1'b1;
    ReqValid = '0;
    RespReady = '0;
    ReqOp1 = '0;
    ReqOp2 = '0;
    do_reset();

    // idle: nothing requested, nothing happens
    repeat (3) @(negedge Clock);
    chk("idle_busy0", 32'(Busy), 32'd0);
    chk("idle_inval0", 32'(AdderInValid), 32'd0);

    // 1.0 + 2.0 from requester 0
    use_fixed = 1'b1;
    run_txn(4'b0001, 2, 0, 1'b0, 1'b0);
    use_fixed = 1'b0;

    // reset while waiting on the adder abandons the op
    stub_lat = 4;
    ReqValid = 4'b0010;
    #1 chk("t4_accept", 32'(ReqReady), 32'(NREQ'(1) << exp_grant(4'b0010, rr_model)));
    @(negedge Clock);
    ReqValid = '0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    reset_values("t4");
    rr_model = 0;
    seen = '0;
    repeat (8) begin
      @(negedge Clock);
      seen |= RespValid;
    end
    chk("t4_no_resp", 32'(seen), 32'd0);
    run_txn(4'b0010, 3, 0, 1'b0, 1'b0);

    // all requesters continuously valid: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 1 + i, 0, 1'b0, 1'b1);

    // requester 2 stalls its response for 10 cycles
    run_txn(4'b0100, 2, 10, 1'b0, 1'b0);

    // stale ResultValid still high when the next op is issued
    run_txn(4'b1001, 1, 0, 1'b1, 1'b0);
    run_txn(4'b0110, 3, 0, 1'b1, 1'b0);
    run_txn(4'b1000, 1, 1, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 12; i++)
      run_txn(NREQ'($urandom_range(1, 15)), $urandom_range(1, 6), $urandom_range(0, 3),
              1'b0, 1'(i % 2));

`ifdef FPARB_TIMEOUT_EN
    // adder never answers: abort after TOUT WAIT cycles
    stub_sticky = 1'b0;
    stub_never = 1'b1;
    ReqValid = 4'b0001;
    @(negedge Clock);
    ReqValid = '0;
    cyc = 1;
    while (RespValid === '0 && cyc < 200) begin
      @(negedge Clock);
      cyc++;
    end
    chk("to_latency", cyc, TOUT + 2);
    chk("to_valid", 32'(RespValid), 32'd1);
    chk("to_result", RespResult, 32'h7FC0_0000);
    chk("to_error", 32'(RespError), 32'd1);
    RespReady = 4'b0001;
    @(negedge Clock);
    RespReady = '0;
    stub_never = 1'b0;
    rr_model = 1;
    run_txn(4'b0001, 2, 0, 1'b0, 1'b0);
`else
    cyc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
